// File: rtl/aplic_idc_arbiter.sv
// ----------------------------------------------------------------------------
// aplic_idc_arbiter
//
// Direct-delivery interrupt arbiter for an APLIC domain. A scan counter sweeps
// sources 1..NR_SRC-1, LANES sources per cycle. Each hart keeps a running best
// candidate, where a lower priority value wins and ties go to the lower iid.
// On the last cycle of every sweep, each accumulator is committed into that
// hart's topi register. A claim returns the committed iid as a pending-clear
// pulse, or acknowledges a forced interrupt when no iid is committed.
//
// Optional feature macro: APLIC_IDC_THRESHOLD_EN
//   defined   : a source passes when ithreshold==0 or prio < ithreshold
//   undefined : every source passes; i_ithreshold is ignored
//
// Ports
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_pending      [NR_SRC]            per-source pending bits
//   i_enabled      [NR_SRC]            per-source enable bits
//   i_target_hart  [NR_SRC*HART_W]     per-source target hart index
//   i_target_prio  [NR_SRC*PRIO_W]     per-source iprio (0 is treated as 1)
//   i_idelivery    [NR_HARTS]          per-hart delivery enable
//   i_iforce       [NR_HARTS]          per-hart force bit
//   i_ithreshold   [NR_HARTS*PRIO_W]   per-hart priority threshold
//   i_claim        claimi read strobe
//   i_claim_hart   [HART_W]            hart being claimed
//   o_topi         [NR_HARTS*(10+PRIO_W)] per-hart {iid[9:0], prio}
//   o_irq          [NR_HARTS]          per-hart interrupt line
//   o_clr_valid    pending-clear pulse
//   o_clr_iid      [10]                source to clear
//   o_iforce_clr   [NR_HARTS]          one-cycle pulse clearing a hart's iforce
// ----------------------------------------------------------------------------
module aplic_idc_arbiter #(
    parameter int NR_SRC   = 32,
    parameter int NR_HARTS = 2,
    parameter int PRIO_W   = 8,
    parameter int LANES    = 4,
    localparam int HART_W  = (NR_HARTS > 1) ? $clog2(NR_HARTS) : 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [NR_SRC-1:0]                 i_pending,
    input  logic [NR_SRC-1:0]                 i_enabled,
    input  logic [NR_SRC*HART_W-1:0]          i_target_hart,
    input  logic [NR_SRC*PRIO_W-1:0]          i_target_prio,
    input  logic [NR_HARTS-1:0]               i_idelivery,
    input  logic [NR_HARTS-1:0]               i_iforce,
    input  logic [NR_HARTS*PRIO_W-1:0]        i_ithreshold,
    input  logic                              i_claim,
    input  logic [HART_W-1:0]                 i_claim_hart,
    output logic [NR_HARTS*(10+PRIO_W)-1:0]   o_topi,
    output logic [NR_HARTS-1:0]               o_irq,
    output logic                              o_clr_valid,
    output logic [9:0]                        o_clr_iid,
    output logic [NR_HARTS-1:0]               o_iforce_clr
);

    localparam int ENTRY_W = 10 + PRIO_W;
    localparam int SWEEP   = (NR_SRC - 1 + LANES - 1) / LANES;
    localparam int CNT_W   = (SWEEP > 1) ? $clog2(SWEEP) : 1;
    localparam int SRC_IW  = $clog2(NR_SRC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWEEP - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0]   scan_cnt;
    logic               sweep_last;

    logic [9:0]         acc_iid   [NR_HARTS];
    logic [PRIO_W-1:0]  acc_prio  [NR_HARTS];
    logic [9:0]         topi_iid  [NR_HARTS];
    logic [PRIO_W-1:0]  topi_prio [NR_HARTS];

    // mask_cur hides claimed iids from the sweep in progress; mask_next
    // carries them through the whole following sweep.
    logic [NR_SRC-1:0]  mask_cur;
    logic [NR_SRC-1:0]  mask_next;

    logic               clr_valid;
    logic [9:0]         clr_iid;
    logic [NR_HARTS-1:0] iforce_clr;

    // ------------------------------------------------------------------------
    // Per-source views of the packed inputs
    // ------------------------------------------------------------------------
    logic [HART_W-1:0]  src_tgt  [NR_SRC];
    logic [PRIO_W-1:0]  src_prio [NR_SRC];
    logic [NR_SRC-1:0]  claim_bit;

    // ------------------------------------------------------------------------
    // Claim decode
    // ------------------------------------------------------------------------
    logic               claim_ok;
    logic [9:0]         claim_iid;
    logic               claim_frc;
    logic [NR_HARTS-1:0] claim_sel;
    logic               claim_clr;
    logic               claim_force;

    // Best candidate after merging this cycle's lanes into the accumulators
    logic [9:0]         best_iid  [NR_HARTS];
    logic [PRIO_W-1:0]  best_prio [NR_HARTS];

    assign sweep_last = (scan_cnt == CNT_LAST);

    for (genvar g = 0; g < NR_SRC; g++) begin : g_src
        assign src_tgt[g]   = i_target_hart[g*HART_W +: HART_W];
        assign src_prio[g]  = (i_target_prio[g*PRIO_W +: PRIO_W] == '0)
                              ? PRIO_W'(1)
                              : i_target_prio[g*PRIO_W +: PRIO_W];
        assign claim_bit[g] = claim_clr && (claim_iid == 10'(g));
    end

`ifdef APLIC_IDC_THRESHOLD_EN
    logic [PRIO_W-1:0]  hart_thr [NR_HARTS];

    for (genvar g = 0; g < NR_HARTS; g++) begin : g_thr
        assign hart_thr[g] = i_ithreshold[g*PRIO_W +: PRIO_W];
    end
`else
    logic unused_thr;

    assign unused_thr = ^i_ithreshold;
`endif

    // A hart index outside 0..NR_HARTS-1 matches no hart, so such claims
    // fall through with no effect.
    always_comb begin
        claim_ok  = 1'b0;
        claim_iid = '0;
        claim_frc = 1'b0;
        claim_sel = '0;
        for (int unsigned h = 0; h < NR_HARTS; h++) begin
            if (i_claim && (i_claim_hart == HART_W'(h))) begin
                claim_ok     = 1'b1;
                claim_iid    = topi_iid[h];
                claim_frc    = i_iforce[h];
                claim_sel[h] = 1'b1;
            end
        end
    end

    assign claim_clr   = claim_ok && (claim_iid != '0);
    assign claim_force = claim_ok && (claim_iid == '0) && claim_frc;

    // ------------------------------------------------------------------------
    // Lane compare and accumulator merge
    // ------------------------------------------------------------------------
    // A claimed iid may already sit in the accumulator from earlier in this
    // sweep; it is dropped so the commit cannot reselect it. The runner-up is
    // not tracked, so that hart may commit a weaker result for one sweep.
    always_comb begin
        logic [31:0]        lane_num;
        logic [SRC_IW-1:0]  lane_idx;
        logic               lane_ok;
        logic               thr_ok;

        lane_num = '0;
        lane_idx = '0;
        lane_ok  = 1'b0;
        thr_ok   = 1'b0;

        for (int unsigned h = 0; h < NR_HARTS; h++) begin
            best_iid[h]  = acc_iid[h];
            best_prio[h] = acc_prio[h];
            if (claim_clr && (acc_iid[h] == claim_iid)) begin
                best_iid[h]  = '0;
                best_prio[h] = '0;
            end
        end

        for (int unsigned l = 0; l < LANES; l++) begin
            lane_num = 32'(scan_cnt) * 32'(LANES) + 32'(l) + 32'd1;
            lane_idx = SRC_IW'(lane_num);
            lane_ok  = (lane_num < 32'(NR_SRC))
                       && i_pending[lane_idx]
                       && i_enabled[lane_idx]
                       && !mask_cur[lane_idx]
                       && !claim_bit[lane_idx];

            for (int unsigned h = 0; h < NR_HARTS; h++) begin
`ifdef APLIC_IDC_THRESHOLD_EN
                thr_ok = (hart_thr[h] == '0) || (src_prio[lane_idx] < hart_thr[h]);
`else
                thr_ok = 1'b1;
`endif
                if (lane_ok && thr_ok && (src_tgt[lane_idx] == HART_W'(h))) begin
                    if ((best_iid[h] == '0)
                        || (src_prio[lane_idx] < best_prio[h])
                        || ((src_prio[lane_idx] == best_prio[h])
                            && (10'(lane_num) < best_iid[h]))) begin
                        best_iid[h]  = 10'(lane_num);
                        best_prio[h] = src_prio[lane_idx];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scan_cnt   <= '0;
            mask_cur   <= '0;
            mask_next  <= '0;
            clr_valid  <= 1'b0;
            clr_iid    <= '0;
            iforce_clr <= '0;
            for (int unsigned h = 0; h < NR_HARTS; h++) begin
                acc_iid[h]   <= '0;
                acc_prio[h]  <= '0;
                topi_iid[h]  <= '0;
                topi_prio[h] <= '0;
            end
        end else begin
            scan_cnt   <= sweep_last ? '0 : scan_cnt + 1'b1;
            clr_valid  <= claim_clr;
            clr_iid    <= claim_clr ? claim_iid : '0;
            iforce_clr <= claim_force ? claim_sel : '0;

            // A claim on the commit cycle only needs to cover the next sweep.
            if (sweep_last) begin
                mask_cur  <= mask_next | claim_bit;
                mask_next <= '0;
            end else begin
                mask_cur  <= mask_cur | claim_bit;
                mask_next <= mask_next | claim_bit;
            end

            for (int unsigned h = 0; h < NR_HARTS; h++) begin
                if (sweep_last) begin
                    acc_iid[h]   <= '0;
                    acc_prio[h]  <= '0;
                    topi_iid[h]  <= best_iid[h];
                    topi_prio[h] <= best_prio[h];
                end else begin
                    acc_iid[h]   <= best_iid[h];
                    acc_prio[h]  <= best_prio[h];
                end
                // Claim overrides a coincident commit for the same hart
                if (claim_clr && claim_sel[h]) begin
                    topi_iid[h]  <= '0;
                    topi_prio[h] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < NR_HARTS; g++) begin : g_out
        assign o_topi[g*ENTRY_W +: ENTRY_W] = {topi_iid[g], topi_prio[g]};
        assign o_irq[g] = i_idelivery[g] & ((topi_iid[g] != '0) | i_iforce[g]);
    end

    assign o_clr_valid  = clr_valid;
    assign o_clr_iid    = clr_iid;
    assign o_iforce_clr = iforce_clr;

endmodule

// File: tb/tb_aplic_idc_arbiter.sv
`timescale 1ns/1ps
module tb_aplic_idc_arbiter;

    localparam int NR_SRC   = 32;
    localparam int NR_HARTS = 2;
    localparam int PRIO_W   = 8;
    localparam int LANES    = 4;
    localparam int HART_W   = 1;
    localparam int S        = 8;
    localparam int ENTRY_W  = 10 + PRIO_W;

    logic                            clk = 1'b0;
    logic                            rst = 1'b1;
    logic [NR_SRC-1:0]               pending;
    logic [NR_SRC-1:0]               enabled;
    logic [NR_SRC*HART_W-1:0]        target_bus;
    logic [NR_SRC*PRIO_W-1:0]        prio_bus;
    logic [NR_HARTS-1:0]             idelivery;
    logic [NR_HARTS-1:0]             iforce;
    logic [NR_HARTS*PRIO_W-1:0]      thr_bus;
    logic                            claim;
    logic [HART_W-1:0]               claim_hart;
    logic [NR_HARTS*ENTRY_W-1:0]     o_topi;
    logic [NR_HARTS-1:0]             o_irq;
    logic                            o_clr_valid;
    logic [9:0]                      o_clr_iid;
    logic [NR_HARTS-1:0]             o_iforce_clr;

    logic [HART_W-1:0]  tgt_arr  [NR_SRC];
    logic [PRIO_W-1:0]  prio_arr [NR_SRC];
    logic [PRIO_W-1:0]  thr_arr  [NR_HARTS];
    logic [ENTRY_W-1:0] topi_arr [NR_HARTS];

    int total = 0;
    int bad   = 0;
    int phase = 0;
    logic [9:0] clr_q [$];

    for (genvar g = 0; g < NR_SRC; g++) begin : g_pack_src
        assign target_bus[g*HART_W +: HART_W] = tgt_arr[g];
        assign prio_bus[g*PRIO_W +: PRIO_W]   = prio_arr[g];
    end
    for (genvar g = 0; g < NR_HARTS; g++) begin : g_pack_hart
        assign thr_bus[g*PRIO_W +: PRIO_W] = thr_arr[g];
        assign topi_arr[g] = o_topi[g*ENTRY_W +: ENTRY_W];
    end

    aplic_idc_arbiter #(
        .NR_SRC   (NR_SRC),
        .NR_HARTS (NR_HARTS),
        .PRIO_W   (PRIO_W),
        .LANES    (LANES)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pending     (pending),
        .i_enabled     (enabled),
        .i_target_hart (target_bus),
        .i_target_prio (prio_bus),
        .i_idelivery   (idelivery),
        .i_iforce      (iforce),
        .i_ithreshold  (thr_bus),
        .i_claim       (claim),
        .i_claim_hart  (claim_hart),
        .o_topi        (o_topi),
        .o_irq         (o_irq),
        .o_clr_valid   (o_clr_valid),
        .o_clr_iid     (o_clr_iid),
        .o_iforce_clr  (o_iforce_clr)
    );

    always #5 clk = ~clk;

    // Sweep position: phase == S-1 during the commit cycle
    always @(posedge clk) begin
        if (rst) phase <= 0;
        else     phase <= (phase == S - 1) ? 0 : phase + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [ENTRY_W-1:0] ent(input int iid, input int p);
        return {10'(iid), PRIO_W'(p)};
    endfunction

    task automatic set_src(input logic [4:0] s, input logic [HART_W-1:0] h,
                           input logic [PRIO_W-1:0] p, input logic pend);
        pending[s]  = pend;
        enabled[s]  = 1'b1;
        tgt_arr[s]  = h;
        prio_arr[s] = p;
    endtask

    task automatic wait_topi(input string tag, input int h, input logic [ENTRY_W-1:0] exp);
        int n;
        n = 0;
        while (topi_arr[h] !== exp && n < 2 * S) begin
            tick(1);
            n++;
        end
        check(tag, 32'(topi_arr[h]), 32'(exp));
    endtask

    // Scoreboard: every clear pulse must match the oldest expected iid
    always @(posedge clk) begin
        #1;
        if (o_clr_valid === 1'b1) begin
            if (clr_q.size() == 0) check("clr_spurious", 32'(o_clr_valid), 32'd0);
            else                   check("clr_iid", 32'(o_clr_iid), 32'(clr_q.pop_front()));
        end
    end

    initial begin
        logic reselect;
        pending    = '0;
        enabled    = '0;
        idelivery  = '0;
        iforce     = '0;
        claim      = 1'b0;
        claim_hart = '0;
        for (int i = 0; i < NR_SRC; i++) begin
            tgt_arr[i]  = '0;
            prio_arr[i] = '0;
        end
        for (int i = 0; i < NR_HARTS; i++) thr_arr[i] = '0;

        // Reset state
        set_src(5'd5, 1'b0, 8'd3, 1'b1);
        idelivery = 2'b11;
        iforce    = 2'b10;
        tick(3);
        check("rst_topi0", 32'(topi_arr[0]), 32'd0);
        check("rst_topi1", 32'(topi_arr[1]), 32'd0);
        check("rst_clr_valid", 32'(o_clr_valid), 32'd0);
        check("rst_iforce_clr", 32'(o_iforce_clr), 32'd0);
        check("rst_irq_force_only", 32'(o_irq), 32'h2);
        iforce = 2'b00;

        // First commit lands exactly S cycles after reset release
        rst = 1'b0;
        tick(S - 1);
        check("first_commit_early", 32'(topi_arr[0]), 32'd0);
        tick(1);
        check("first_commit", 32'(topi_arr[0]), 32'(ent(5, 3)));

        // Equal priority: lower iid wins across sweep cycles
        set_src(5'd9, 1'b0, 8'd3, 1'b1);
        tick(2 * S);
        check("tie_lower_iid", 32'(topi_arr[0]), 32'(ent(5, 3)));
        check("irq0", 32'(o_irq[0]), 32'd1);
        idelivery[0] = 1'b0;
        #1;
        check("irq0_gated", 32'(o_irq[0]), 32'd0);
        idelivery[0] = 1'b1;

        // Priority 0 behaves as 1; tie inside one lane group goes to lower iid
        set_src(5'd6, 1'b0, 8'd0, 1'b1);
        wait_topi("prio0_as_1", 0, ent(6, 1));
        set_src(5'd8, 1'b0, 8'd1, 1'b1);
        tick(2 * S);
        check("tie_in_lanes", 32'(topi_arr[0]), 32'(ent(6, 1)));
        pending[6] = 1'b0;
        pending[8] = 1'b0;
        wait_topi("recover_5", 0, ent(5, 3));

        // Threshold on hart 1
        thr_arr[1] = 8'd2;
        set_src(5'd7, 1'b1, 8'd2, 1'b1);
        tick(2 * S);
`ifdef APLIC_IDC_THRESHOLD_EN
        check("thr_blocks", 32'(topi_arr[1]), 32'd0);
`else
        check("thr_ignored", 32'(topi_arr[1]), 32'(ent(7, 2)));
`endif
        thr_arr[1] = 8'd3;
        wait_topi("thr_passes", 1, ent(7, 2));

        // Claim hart 0: clear pulse, topi cleared, iid 5 masked a full sweep
        clr_q.push_back(10'd5);
        claim      = 1'b1;
        claim_hart = 1'b0;
        tick(1);
        claim = 1'b0;
        check("claim_topi_clear", 32'(topi_arr[0]), 32'd0);
        check("claim_clr_valid", 32'(o_clr_valid), 32'd1);
        reselect = 1'b0;
        for (int i = 0; i < 2 * S - 1; i++) begin
            tick(1);
            if (topi_arr[0][ENTRY_W-1:PRIO_W] == 10'd5) reselect = 1'b1;
        end
        check("no_reselect", 32'(reselect), 32'd0);
        check("masked_alt", 32'(topi_arr[0]), 32'(ent(9, 3)));
        wait_topi("unmasked_5", 0, ent(5, 3));

        // Claim on the commit cycle: claim wins for hart 0, hart 1 commits
        for (int i = 0; i < S && phase != S - 1; i++) tick(1);
        set_src(5'd3, 1'b1, 8'd1, 1'b1);
        tick(S);
        check("pre_commit_topi0", 32'(topi_arr[0]), 32'(ent(5, 3)));
        check("pre_commit_topi1", 32'(topi_arr[1]), 32'(ent(7, 2)));
        clr_q.push_back(10'd5);
        claim      = 1'b1;
        claim_hart = 1'b0;
        tick(1);
        claim = 1'b0;
        check("commit_claim_topi0", 32'(topi_arr[0]), 32'd0);
        check("commit_other_hart", 32'(topi_arr[1]), 32'(ent(3, 1)));

        // Forced interrupt with empty topi
        pending[3] = 1'b0;
        pending[7] = 1'b0;
        wait_topi("hart1_empty", 1, '0);
        iforce[1] = 1'b1;
        #1;
        check("iforce_irq", 32'(o_irq[1]), 32'd1);
        claim      = 1'b1;
        claim_hart = 1'b1;
        tick(1);
        claim = 1'b0;
        check("iforce_clr_pulse", 32'(o_iforce_clr), 32'h2);
        check("iforce_no_clr", 32'(o_clr_valid), 32'd0);
        tick(1);
        check("iforce_clr_once", 32'(o_iforce_clr), 32'd0);
        iforce[1] = 1'b0;

        // Back-to-back claims on consecutive cycles
        pending[7] = 1'b1;
        wait_topi("refill_hart1", 1, ent(7, 2));
        wait_topi("refill_hart0", 0, ent(5, 3));
        clr_q.push_back(10'd5);
        claim      = 1'b1;
        claim_hart = 1'b0;
        tick(1);
        check("b2b_first", 32'(topi_arr[0]), 32'd0);
        clr_q.push_back(10'd7);
        claim_hart = 1'b1;
        tick(1);
        claim = 1'b0;
        check("b2b_second", 32'(topi_arr[1]), 32'd0);
        tick(2);

        // Reset mid-sweep abandons it; first commit S cycles after release
        for (int i = 0; i < S && phase != 3; i++) tick(1);
        rst = 1'b1;
        tick(2);
        check("midrst_topi0", 32'(topi_arr[0]), 32'd0);
        check("midrst_topi1", 32'(topi_arr[1]), 32'd0);
        check("midrst_clr", 32'(o_clr_valid), 32'd0);
        rst = 1'b0;
        tick(S - 1);
        check("post_rst_early", 32'(topi_arr[0]), 32'd0);
        tick(1);
        check("post_rst_commit0", 32'(topi_arr[0]), 32'(ent(5, 3)));
        check("post_rst_commit1", 32'(topi_arr[1]), 32'(ent(7, 2)));

        tick(2);
        check("scoreboard_drained", 32'(clr_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aplic_idc_arbiter.md
APLIC_IDC_ARBITER -- requirements
Module: aplic_idc_arbiter

Interface
REQ-001 SHALL have parameter NR_SRC, default 32, meaning the number of sources including reserved source 0 (range 2..1024).
REQ-002 SHALL have parameter NR_HARTS, default 2, meaning the number of direct-mode harts served (1..16).
REQ-003 SHALL have parameter PRIO_W, default 8, meaning the priority width.
REQ-004 SHALL have parameter LANES, default 4, meaning the number of sources compared per cycle (power of 2, at most NR_SRC).
REQ-005 SHALL use one clock and a synchronous, active-high reset; ports i_clk and i_rst are defined below.
REQ-006 i_clk  in  1  clock.
REQ-007 i_rst  in  1  synchronous active-high reset.
REQ-008 i_pending  in  NR_SRC  per-source pending bits.
REQ-009 i_enabled  in  NR_SRC  per-source enable bits.
REQ-010 i_target_hart  in  NR_SRC*HART_W  per-source target hart index; HART_W = max(1, clog2(NR_HARTS)).
REQ-011 i_target_prio  in  NR_SRC*PRIO_W  per-source iprio.
REQ-012 i_idelivery  in  NR_HARTS  per-hart delivery enable.
REQ-013 i_iforce  in  NR_HARTS  per-hart force bit.
REQ-014 i_ithreshold  in  NR_HARTS*PRIO_W  per-hart threshold.
REQ-015 i_claim  in  1  claimi read strobe.
REQ-016 i_claim_hart  in  HART_W  hart being claimed.
REQ-017 o_topi  out  NR_HARTS*(10+PRIO_W)  per-hart {iid[9:0], prio}.
REQ-018 o_irq  out  NR_HARTS  per-hart interrupt line.
REQ-019 o_clr_valid  out  1  pending-clear pulse.
REQ-020 o_clr_iid  out  10  source to clear.
REQ-021 o_iforce_clr  out  NR_HARTS  one-cycle pulse that clears the hart's iforce.

Function
REQ-022 SHALL sweep sources 1..NR_SRC-1 with a scan counter advancing LANES sources per cycle; sweep length is S = ceil((NR_SRC-1)/LANES) cycles, and the sweep restarts immediately with no idle cycle.
REQ-023 A source is a candidate for hart h when all of the following hold: pending=1, enabled=1, target_hart=h, target_hart<NR_HARTS, and the threshold test (REQ-024) passes.
REQ-024 Threshold test: pass if ithreshold[h]==0 or prio<ithreshold[h].
REQ-025 An input priority of 0 SHALL be treated as 1.
REQ-026 Per hart, the block SHALL keep a best-candidate accumulator: a lower prio value wins, and on equal prio the lower iid wins, including across lanes in the same cycle.
REQ-027 On the last cycle of a sweep, every hart's accumulator (merged with that cycle's lanes) SHALL load into its topi register, and the accumulators reset to empty ({0,0}).
REQ-028 o_topi reflects committed sweep results only; a change seen in the inputs SHALL appear at o_topi within 2*S cycles.
REQ-029 o_irq[h] = i_idelivery[h] & (topi_iid[h]!=0 | i_iforce[h]), and SHALL be combinational from the topi register.
REQ-030 Claim with topi_iid[h]!=0: the next cycle SHALL pulse o_clr_valid=1 with o_clr_iid=topi_iid[h]; topi[h] clears to 0 in that same cycle.
REQ-031 Claim with topi_iid[h]==0 and i_iforce[h]=1: the next cycle SHALL pulse o_iforce_clr[h]; there is no clr pulse.
REQ-032 Claim with topi_iid[h]==0 and i_iforce[h]=0: no effect.
REQ-033 A claim with i_claim_hart>=NR_HARTS SHALL be ignored.
REQ-034 A claimed iid SHALL be masked from the sweep in progress and from the following full sweep, so that the stale pending bit is not re-selected.
REQ-035 If a claim and a sweep commit coincide for the same hart, the claim wins: topi[h] clears, and the commit for that hart is discarded.
REQ-036 Only one claim is accepted per cycle; consecutive-cycle claims SHALL each be honoured.

Reset
REQ-037 While i_rst=1: scan counter=0, accumulators empty, all topi=0, mask cleared, o_clr_valid=0, o_clr_iid=0, o_iforce_clr=0, and o_irq follows REQ-029 (iforce path only).
REQ-038 A reset asserted mid-sweep SHALL abandon the sweep; the first commit after reset release occurs S cycles later.

Configuration
REQ-039 Macro APLIC_IDC_THRESHOLD_EN.
REQ-040 With APLIC_IDC_THRESHOLD_EN defined, REQ-024 applies.
REQ-041 Without APLIC_IDC_THRESHOLD_EN, the threshold test always passes, i_ithreshold is ignored, and its logic is removed.

Verification (NR_SRC=32, NR_HARTS=2, LANES=4, S=8, APLIC_IDC_THRESHOLD_EN defined unless noted)
REQ-042 Src 5 (prio 3) and src 9 (prio 3) both pending+enabled to hart 0, idelivery=1 -> within 16 cycles topi[0]={5,3} and o_irq[0]=1.
REQ-043 Src 7 at prio 2 to hart 1 with ithreshold[1]=2 -> topi[1]=0; set ithreshold[1]=3 -> topi[1]={7,2} within 16 cycles.
REQ-044 Repeat REQ-043 without APLIC_IDC_THRESHOLD_EN -> topi[1]={7,2} with ithreshold[1]=2.
REQ-045 topi[0]={5,3}, claim hart 0 -> next cycle o_clr_valid=1, o_clr_iid=5, topi[0]=0; src 5's pending held at 1 -> src 5 is not selected for the following full sweep.
REQ-046 Claim on the commit cycle for hart 0 -> topi[0]=0 and the commit for hart 0 is discarded; hart 1 still commits.
REQ-047 topi[1]=0, iforce[1]=1, idelivery[1]=1 -> o_irq[1]=1; claim hart 1 -> o_iforce_clr[1] pulses one cycle and o_clr_valid=0.
